pc_redirect: RTL and testbench

PC_REDIRECT -- requirements
Module: pc_redirect

---
 rtl/pc_redirect.sv | 105 ++++++++++
 tb/tb_pc_redirect.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect.sv
// Fetch PC register with exception/mret/branch redirect, stall hold and post-redirect flush bubbles.
// Optional PC_REDIRECT_MISALIGN_CHECK_EN: misaligned mret/branch targets raise a flag instead of redirecting.
module pc_redirect #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        initiate_exception,
   input  logic [31:0] csr_mtvec,
   input  logic        mret,
   input  logic [31:0] csr_mepc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [31:0] nextPC,
   output logic        bubble,
   output logic        trap_active,
   output logic        exception_instruction_misaligned
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        pc_q, pc_d;
   logic               trap_q, trap_d;
   logic               mis_q, mis_d;

   logic               in_flush;
   logic               mret_v;
   logic               br_v;
   logic               redirect;
   logic               mis_c;
   logic [31:0]        mepc_t;
   logic [31:0]        br_t;

   // Redirect selection and flush sequencing
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      trap_d   = trap_q;
      in_flush = (state_q == FLUSH);
      mret_v   = mret & ~in_flush;
      br_v     = branch_taken & ~in_flush;
      redirect = initiate_exception | mret_v | br_v;
`ifdef PC_REDIRECT_MISALIGN_CHECK_EN
      mepc_t   = csr_mepc;
      br_t     = branch_target;
      mis_c    = ~initiate_exception &
                 (mret_v ? (csr_mepc[1:0] != 2'b00)
                         : (br_v & (branch_target[1:0] != 2'b00)));
`else
      mepc_t   = csr_mepc & ~32'h3;
      br_t     = branch_target & ~32'h3;
      mis_c    = 1'b0;
`endif
      mis_d    = mis_c;

      if (initiate_exception) pc_d = csr_mtvec;
      else if (mis_c)         pc_d = pc_q;
      else if (mret_v)        pc_d = mepc_t;
      else if (br_v)          pc_d = br_t;
      else if (stall)         pc_d = pc_q;
      else                    pc_d = pc_q + 32'd4;

      // Exception wins over a simultaneous mret, so the trap stays active
      if (initiate_exception)           trap_d = 1'b1;
      else if (mret_v && !mis_c)        trap_d = 1'b0;

      if (redirect) begin
         state_d = FLUSH;
         cnt_d   = CNT_W'(FLUSH_CYCLES);
      end else if (in_flush) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) state_d = RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         pc_q    <= RESET_PC;
         trap_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         trap_q  <= trap_d;
         mis_q   <= mis_d;
      end
   end

   assign pc                               = pc_q;
   assign nextPC                           = pc_d;
   assign bubble                           = in_flush | initiate_exception | mret | branch_taken;
   assign trap_active                      = trap_q;
   assign exception_instruction_misaligned = mis_q;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect: sequential fetch, redirect priority, flush bubbles, stall, reset, wrap.
module tb_pc_redirect;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        initiate_exception;
   logic [31:0] csr_mtvec;
   logic        mret;
   logic [31:0] csr_mepc;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic [31:0] nextPC;
   logic        bubble;
   logic        trap_active;
   logic        exception_instruction_misaligned;

   int checks = 0;
   int errors = 0;

   pc_redirect #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
      .clk                              (clk),
      .reset                            (reset),
      .stall                            (stall),
      .initiate_exception               (initiate_exception),
      .csr_mtvec                        (csr_mtvec),
      .mret                             (mret),
      .csr_mepc                         (csr_mepc),
      .branch_taken                     (branch_taken),
      .branch_target                    (branch_target),
      .pc                               (pc),
      .nextPC                           (nextPC),
      .bubble                           (bubble),
      .trap_active                      (trap_active),
      .exception_instruction_misaligned (exception_instruction_misaligned)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      stall              = 1'b0;
      initiate_exception = 1'b0;
      mret               = 1'b0;
      branch_taken       = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clr();
      csr_mtvec = 32'h4; csr_mepc = 32'h40; branch_target = 32'h0;
      step(); step();
      check("rst_pc", pc, 32'h0);
      check("rst_bubble", 32'(bubble), 32'h0);
      check("rst_trap", 32'(trap_active), 32'h0);
      check("rst_mis", 32'(exception_instruction_misaligned), 32'h0);
      reset = 1'b0;

      // Sequential fetch after reset release
      check("seq0", pc, 32'h0);
      check("seq0_next", nextPC, 32'h4);
      step(); check("seq1", pc, 32'h4);
      step(); check("seq2", pc, 32'h8);
      check("seq2_bubble", 32'(bubble), 32'h0);

      // Branch at pc=0x8 to 0x100, two flush cycles follow
      branch_taken = 1'b1; branch_target = 32'h100; #1;
      check("br_next", nextPC, 32'h100);
      check("br_bubble0", 32'(bubble), 32'h1);
      step(); clr();
      check("br_pc", pc, 32'h100);
      check("br_bubble1", 32'(bubble), 32'h1);
      step(); check("br_pc2", pc, 32'h104);
      check("br_bubble2", 32'(bubble), 32'h1);
      step(); check("br_pc3", pc, 32'h108);
      check("br_bubble3", 32'(bubble), 32'h0);

      // All three redirects together: exception wins
      initiate_exception = 1'b1; mret = 1'b1; branch_taken = 1'b1; branch_target = 32'h200; #1;
      check("prio_next", nextPC, 32'h4);
      step(); clr();
      check("prio_pc", pc, 32'h4);
      check("prio_trap", 32'(trap_active), 32'h1);
      step(); step();
      check("prio_run_pc", pc, 32'hC);
      check("prio_run_bubble", 32'(bubble), 32'h0);
      mret = 1'b1; #1;
      check("mret_next", nextPC, 32'h40);
      step(); clr();
      check("mret_pc", pc, 32'h40);
      check("mret_trap", 32'(trap_active), 32'h0);

      // Branch during FLUSH is ignored and does not reload the counter
      branch_taken = 1'b1; branch_target = 32'h300; #1;
      check("ign_next", nextPC, 32'h44);
      step(); clr();
      check("ign_pc", pc, 32'h44);
      step();
      check("ign_pc2", pc, 32'h48);
      check("ign_bubble", 32'(bubble), 32'h0);

      // Stall holds pc; flush counter still drains
      branch_taken = 1'b1; branch_target = 32'h20;
      step(); clr(); stall = 1'b1;
      check("stall_pc0", pc, 32'h20);
      step(); check("stall_pc1", pc, 32'h20);
      step(); check("stall_pc2", pc, 32'h20);
      check("stall_bubble", 32'(bubble), 32'h0);
      initiate_exception = 1'b1; csr_mtvec = 32'h80;
      step(); clr();
      check("stall_exc_pc", pc, 32'h80);
      check("stall_exc_trap", 32'(trap_active), 32'h1);

      // Exception on the last flush cycle restarts the counter
      step(); check("exp_pc", pc, 32'h84);
      initiate_exception = 1'b1; csr_mtvec = 32'h90;
      step(); clr();
      check("exp_pc2", pc, 32'h90);
      check("exp_bubble", 32'(bubble), 32'h1);
      step(); check("exp_bubble2", 32'(bubble), 32'h1);
      step(); check("exp_pc3", pc, 32'h98);
      check("exp_bubble3", 32'(bubble), 32'h0);

      // Misaligned branch target
      branch_taken = 1'b1; branch_target = 32'h10;
      step(); clr(); step(); step();
      check("mis_start_pc", pc, 32'h18);
      branch_taken = 1'b1; branch_target = 32'h102;
      step(); clr();
`ifdef PC_REDIRECT_MISALIGN_CHECK_EN
      check("mis_pc", pc, 32'h18);
      check("mis_flag", 32'(exception_instruction_misaligned), 32'h1);
      check("mis_bubble", 32'(bubble), 32'h1);
      step();
      check("mis_flag_off", 32'(exception_instruction_misaligned), 32'h0);
`else
      check("mis_pc", pc, 32'h100);
      check("mis_flag", 32'(exception_instruction_misaligned), 32'h0);
      check("mis_bubble", 32'(bubble), 32'h1);
      step();
      check("mis_flag_off", 32'(exception_instruction_misaligned), 32'h0);
`endif
      step();

      // Reset in the middle of a flush
      branch_taken = 1'b1; branch_target = 32'h200;
      step(); clr(); step();
      check("rf_pc", pc, 32'h204);
      check("rf_bubble", 32'(bubble), 32'h1);
      reset = 1'b1; #1;
      check("rf_async_pc", pc, 32'h0);
      check("rf_async_bubble", 32'(bubble), 32'h0);
      step(); reset = 1'b0; #1;
      check("rf_rel_pc", pc, 32'h0);
      check("rf_rel_bubble", 32'(bubble), 32'h0);
      step();
      check("rf_pc1", pc, 32'h4);
      check("rf_bubble1", 32'(bubble), 32'h0);

      // Sequential wrap at the top of the address space
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      step(); clr();
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_next", nextPC, 32'h0);
      step();
      check("wrap_pc2", pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
